// File: rtl/signed_mult_8x8_ctrl_pkg.sv
// Shared types and constants for the sequential signed 8x8 add-shift multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int OP_W   = 8;
    localparam int ADD_W  = 9;
    localparam int N_ITER = 8;
    localparam logic [2:0] LAST_ITER = 3'(N_ITER - 1);

    // One guard bit above the operand keeps -128 x -128 exact.
    function automatic logic [ADD_W-1:0] sext(input logic [OP_W-1:0] v);
        return {v[OP_W-1], v};
    endfunction

endpackage

// File: rtl/lookahead_adder_9.sv
// 9-bit adder built from three 3-bit carry-lookahead groups chained group to group.
module lookahead_adder_9 (
    input  logic [8:0] a,
    input  logic [8:0] b,
    input  logic       cin,
    output logic [8:0] sum,
    output logic       cout
);
    logic [8:0] p;
    logic [8:0] g;
    logic [9:0] c;

    assign p    = a ^ b;
    assign g    = a & b;
    assign c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_group
            localparam int B = gi * 3;
            assign c[B+1] = g[B] | (p[B] & c[B]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & c[B]);
        end
    endgenerate

    assign sum  = p ^ c[8:0];
    assign cout = c[9];
endmodule

// File: rtl/signed_mult_8x8_ctrl_reg_unit.sv
// X/A/B datapath registers: clear, parallel loads and the combined arithmetic right shift.
module reg_unit
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             clear_ax,
    input  logic             load_b,
    input  logic [OP_W-1:0]  b_in,
    input  logic             load_sum,
    input  logic [ADD_W-1:0] sum_in,
    input  logic             shift,
    output logic             x,
    output logic [OP_W-1:0]  a,
    output logic [OP_W-1:0]  b
);
    logic            x_reg;
    logic [OP_W-1:0] a_reg;
    logic [OP_W-1:0] b_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            x_reg <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (clear_ax) begin
                x_reg <= 1'b0;
                a_reg <= '0;
            end else if (load_sum) begin
                x_reg <= sum_in[ADD_W-1];
                a_reg <= sum_in[OP_W-1:0];
            end else if (shift) begin
                a_reg <= {x_reg, a_reg[OP_W-1:1]};
            end

            // A[0] falls into the top of B so {A,B} forms the growing product.
            if (load_b) begin
                b_reg <= b_in;
            end else if (shift) begin
                b_reg <= {a_reg[0], b_reg[OP_W-1:1]};
            end
        end
    end

    assign x = x_reg;
    assign a = a_reg;
    assign b = b_reg;
endmodule

// File: rtl/signed_mult_8x8_ctrl.sv
// Sequential signed 8x8 add-shift multiplier; product in {Aval,Bval} with X as sign.
// Build option MULT_SKIP_ZERO_EN: skip the ADD cycle whenever the next B[0] is 0.
module signed_mult_8x8_ctrl (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       ClearA_LoadB,
    input  logic [7:0] Switches,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic       X,
    output logic       Done
);
    import mult_pkg::*;

    state_t          state_reg;
    logic [2:0]      cnt_reg;
    logic [OP_W-1:0] s_reg;
    logic            done_reg;

    logic             clear_ax;
    logic             load_b;
    logic             load_sum;
    logic             shift;
    logic             is_last;
    logic [ADD_W-1:0] add_a;
    logic [ADD_W-1:0] add_b;
    logic             add_cin;
    logic [ADD_W-1:0] sum;
    logic             cout_unused;

    always_comb begin
        clear_ax = 1'b0;
        load_b   = 1'b0;
        load_sum = 1'b0;
        shift    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                clear_ax = ClearA_LoadB | Run;
                load_b   = ClearA_LoadB;
            end
            ADD:     load_sum = Bval[0];
            SHIFT:   shift    = 1'b1;
            default: ;
        endcase
    end

    // The final partial product carries the multiplier's sign weight, so subtract it.
    assign is_last = (cnt_reg == LAST_ITER);
    assign add_a   = sext(Aval);
    assign add_b   = is_last ? ~sext(s_reg) : sext(s_reg);
    assign add_cin = is_last;

    lookahead_adder_9 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (sum),
        .cout (cout_unused)
    );

    reg_unit u_regs (
        .clk      (Clk),
        .srst     (Reset),
        .clear_ax (clear_ax),
        .load_b   (load_b),
        .b_in     (Switches),
        .load_sum (load_sum),
        .sum_in   (sum),
        .shift    (shift),
        .x        (X),
        .a        (Aval),
        .b        (Bval)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            s_reg     <= '0;
            done_reg  <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (!ClearA_LoadB && Run) begin
                        s_reg   <= Switches;
                        cnt_reg <= 3'd0;
`ifdef MULT_SKIP_ZERO_EN
                        state_reg <= Bval[0] ? ADD : SHIFT;
`else
                        state_reg <= ADD;
`endif
                    end
                end
                ADD: state_reg <= SHIFT;
                SHIFT: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (is_last) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else begin
`ifdef MULT_SKIP_ZERO_EN
                        // Bval[1] becomes B[0] once this shift lands.
                        state_reg <= Bval[1] ? ADD : SHIFT;
`else
                        state_reg <= ADD;
`endif
                    end
                end
                DONE: begin
                    if (!Run) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign Done = done_reg;
endmodule

// File: tb/tb_signed_mult_8x8_ctrl.sv
// Scoreboard bench for signed_mult_8x8_ctrl: expected products queued at start, checked at Done.
module tb_signed_mult_8x8_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] Switches;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       X;
    logic       Done;

    always #5 Clk = ~Clk;

    signed_mult_8x8_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .Switches     (Switches),
        .Aval         (Aval),
        .Bval         (Bval),
        .X            (X),
        .Done         (Done)
    );

    typedef struct packed {
        logic       x;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] lat;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] b_model;
    int         errors = 0;
    int         checks = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_latency(input logic [7:0] b);
`ifdef MULT_SKIP_ZERO_EN
        return 8'(8 + $countones(b));
`else
        return 8'd16;
`endif
    endfunction

    task automatic do_load(input logic [7:0] v);
        ClearA_LoadB = 1'b1;
        Switches     = v;
        @(posedge Clk); #1;
        ClearA_LoadB = 1'b0;
        b_model      = v;
        check_val("load_a", Aval, 8'h00);
        check_val("load_x", X, 1'b0);
        check_val("load_b", Bval, v);
    endtask

    task automatic do_mult(input logic [7:0] s, input bit hold_run);
        logic signed [15:0] p;
        exp_t               e;
        int                 n;
        logic [7:0]         b_used;
        b_used = b_model;
        p = $signed(s) * $signed(b_used);
        sb_q.push_back({p[15], p[15:8], p[7:0], exp_latency(b_used)});

        Run      = 1'b1;
        Switches = s;
        @(posedge Clk); #1;
        Switches = ~s;
        n = 0;
        while (!Done && n < 40) begin
            @(posedge Clk); #1;
            n++;
            // Load request mid-run must be ignored.
            if (n == 3) begin
                ClearA_LoadB = 1'b1;
                Switches     = 8'hA5;
            end
            if (n == 4) ClearA_LoadB = 1'b0;
        end
        if (!Done) check_val("done_timeout", Done, 1'b1);

        e = sb_q.pop_front();
        check_val("latency", n, e.lat);
        check_val("prod_a", Aval, e.a);
        check_val("prod_b", Bval, e.b);
        check_val("prod_x", X, e.x);
        $display("mult S=%02h B=%02h -> A=%02h B=%02h X=%0b cycles=%0d", s, b_used, Aval, Bval, X, n);
        b_model = e.b;

        if (hold_run) begin
            repeat (3) begin
                @(posedge Clk); #1;
            end
            check_val("hold_done", Done, 1'b1);
            check_val("hold_a", Aval, e.a);
            check_val("hold_b", Bval, e.b);
        end
        Run = 1'b0;
        @(posedge Clk); #1;
        check_val("idle_done", Done, 1'b0);
        check_val("idle_a", Aval, e.a);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset        = 1'b1;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        Switches     = 8'h00;
        b_model      = 8'h00;
        repeat (2) @(posedge Clk);
        #1;
        check_val("rst_a", Aval, 8'h00);
        check_val("rst_b", Bval, 8'h00);
        check_val("rst_x", X, 1'b0);
        check_val("rst_done", Done, 1'b0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Load beats Run in IDLE: B is loaded and no multiply starts.
        ClearA_LoadB = 1'b1;
        Run          = 1'b1;
        Switches     = 8'h07;
        repeat (3) begin
            @(posedge Clk); #1;
        end
        check_val("prio_a", Aval, 8'h00);
        check_val("prio_b", Bval, 8'h07);
        check_val("prio_done", Done, 1'b0);
        ClearA_LoadB = 1'b0;
        Run          = 1'b0;
        b_model      = 8'h07;
        @(posedge Clk); #1;

        do_mult(8'h3B, 1'b1);
        do_mult(8'h02, 1'b0);
        do_load(8'hFE);
        do_mult(8'h03, 1'b0);
        do_load(8'h80);
        do_mult(8'h80, 1'b0);
        do_load(8'h7F);
        do_mult(8'h80, 1'b0);
        for (int i = 0; i < 6; i++) begin
            do_load(8'($urandom_range(0, 255)));
            do_mult(8'($urandom_range(0, 255)), 1'b0);
        end

        // Reset on the 5th cycle of a run aborts it.
        do_load(8'hC3);
        Run      = 1'b1;
        Switches = 8'h5A;
        @(posedge Clk); #1;
        repeat (4) begin
            @(posedge Clk); #1;
        end
        Reset = 1'b1;
        @(posedge Clk); #1;
        check_val("abort_a", Aval, 8'h00);
        check_val("abort_b", Bval, 8'h00);
        check_val("abort_x", X, 1'b0);
        check_val("abort_done", Done, 1'b0);
        Reset   = 1'b0;
        Run     = 1'b0;
        b_model = 8'h00;
        repeat (2) begin
            @(posedge Clk); #1;
        end
        check_val("abort_idle_done", Done, 1'b0);
        do_mult(8'h55, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
